// File: rtl/arbitro_rr_fifo2_pkg.sv
// Shared definitions for the two-source round-robin arbiter: FSM encodings and
// default sizing of the datapath and burst limit.
package arbitro_rr_fifo2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SERVE0 = 2'b01,
        ST_SERVE1 = 2'b10,
        ST_HOLD   = 2'b11
    } arb_state_t;

    localparam int DEFAULT_DATA_WIDTH = 4;
    localparam int DEFAULT_BURST_MAX  = 4;

    function automatic arb_state_t serve_state(input logic g);
        return g ? ST_SERVE1 : ST_SERVE0;
    endfunction

endpackage

// File: rtl/arbitro_rr_fifo2_mux2_valid_reg.sv
// Registered 2:1 output stage: captures the word popped one cycle earlier and
// presents it with a valid flag; data is forced to zero whenever nothing is valid.
module mux2_valid_reg
    import arbitro_rr_fifo2_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  pend,
    input  logic                  src,
    input  logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  selector
);

    logic [DATA_WIDTH-1:0] mux_w;
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  valid_d, valid_q;
    logic                  sel_d, sel_q;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_mux
            assign mux_w[gi] = src ? d1[gi] : d0[gi];
        end
    endgenerate

    // selector keeps pointing at the last real source across empty cycles
    always_comb begin
        valid_d = pend;
        data_d  = pend ? mux_w : '0;
        sel_d   = pend ? src : sel_q;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign selector  = sel_q;

endmodule

// File: rtl/arbitro_rr_fifo2.sv
// Round-robin arbiter with burst-limited stickiness popping two source FIFOs into
// one registered output; stops popping under downstream backpressure.
module arbitro_rr_fifo2
    import arbitro_rr_fifo2_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_MAX  = DEFAULT_BURST_MAX
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  fifo0_empty,
    input  logic                  fifo1_empty,
    input  logic [DATA_WIDTH-1:0] fifo0_data,
    input  logic [DATA_WIDTH-1:0] fifo1_data,
    input  logic                  almost_full,
    output logic                  pop0,
    output logic                  pop1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  selector,
    output logic [1:0]            state,
    output logic                  idle
);

    localparam int              CNT_W   = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    arb_state_t       state_d, state_q;
    logic             last_d, last_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             pend_d, pend_q;
    logic             src_d, src_q;

    logic e0, e1;
    logic grant;
    logic gsel;

    assign e0 = !fifo0_empty;
    assign e1 = !fifo1_empty;

    always_comb begin
        grant = 1'b0;
        gsel  = last_q;
        if (almost_full) begin
            grant = 1'b0;
        end else if (!e0 && !e1) begin
            grant = 1'b0;
        end else if (e0 != e1) begin
            grant = 1'b1;
            gsel  = e1;
        end else begin
            // both sources waiting: stay sticky until the burst budget is spent
            grant = 1'b1;
            case (state_q)
                ST_SERVE0: gsel = (cnt_q < CNT_MAX) ? 1'b0 : 1'b1;
                ST_SERVE1: gsel = (cnt_q < CNT_MAX) ? 1'b1 : 1'b0;
                default:   gsel = !last_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pend_d  = grant;
        src_d   = src_q;
        if (almost_full) begin
            state_d = ST_HOLD;
        end else if (!grant) begin
            state_d = ST_IDLE;
        end else begin
            state_d = serve_state(gsel);
        end
        if (grant) begin
            last_d = gsel;
            src_d  = gsel;
            if ((gsel == last_q) && (state_q == serve_state(gsel))) begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            src_q   <= src_d;
        end
    end

    // pops are gated by reset so nothing is read while the registers are held clear
    assign pop0 = reset_L && grant && !gsel;
    assign pop1 = reset_L && grant && gsel;

    mux2_valid_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clk      (clk),
        .reset_L  (reset_L),
        .pend     (pend_q),
        .src      (src_q),
        .d0       (fifo0_data),
        .d1       (fifo1_data),
        .data_out (data_out),
        .valid_out(valid_out),
        .selector (selector)
    );

    assign state = state_q;
    assign idle  = (state_q == ST_IDLE) && !pend_q && !valid_out;

endmodule

// File: tb/tb_arbitro_rr_fifo2.sv
// Bench for arbitro_rr_fifo2: queue-backed FIFO models, a table of grant vectors,
// hand sequences for backpressure, draining and asynchronous reset.
module tb_arbitro_rr_fifo2;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          fifo0_empty = 1'b1;
    logic          fifo1_empty = 1'b1;
    logic [DW-1:0] fifo0_data = '0;
    logic [DW-1:0] fifo1_data = '0;
    logic          almost_full = 1'b0;
    logic          pop0, pop1;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          selector;
    logic [1:0]    state;
    logic          idle;

    arbitro_rr_fifo2 #(
        .DATA_WIDTH(DW),
        .BURST_MAX (4)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .fifo0_empty(fifo0_empty),
        .fifo1_empty(fifo1_empty),
        .fifo0_data (fifo0_data),
        .fifo1_data (fifo1_data),
        .almost_full(almost_full),
        .pop0       (pop0),
        .pop1       (pop1),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .selector   (selector),
        .state      (state),
        .idle       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sel;
        logic [DW-1:0] d;
        int            due;
    } sb_t;

    typedef struct packed {
        logic       m0;
        logic       m1;
        logic       af;
        logic       xp0;
        logic       xp1;
        logic [1:0] xst;
    } vec_t;

    sb_t           sb[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    bit            en0 = 1'b0;
    bit            en1 = 1'b0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    vec_t          vecs[22];

    function automatic vec_t mk(input logic m0, input logic m1, input logic af,
                                input logic xp0, input logic xp1, input logic [1:0] xst);
        vec_t v;
        v.m0 = m0; v.m1 = m1; v.af = af; v.xp0 = xp0; v.xp1 = xp1; v.xst = xst;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic check_out();
        sb_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("valid_out", 32'(valid_out), 32'd1);
            check("data_out", 32'(data_out), 32'(e.d));
            check("selector", 32'(selector), 32'(e.sel));
            $display("cycle %0d: word src=%0d data=%h", cyc, e.sel, e.d);
        end else begin
            check("valid_out quiet", 32'(valid_out), 32'd0);
            check("data_out zero", 32'(data_out), 32'd0);
        end
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            q0.push_back(DW'($urandom_range(0, 15)));
            q1.push_back(DW'($urandom_range(0, 15)));
        end
    endtask

    // One clock cycle: drive flags, check pops, advance, model FIFO read data, check outputs.
    task automatic tick(input bit chk_pop, input logic xp0, input logic xp1,
                        input bit chk_st, input logic [1:0] xst);
        logic          p0, p1, bad;
        logic [DW-1:0] w;
        fifo0_empty = !(en0 && q0.size() != 0);
        fifo1_empty = !(en1 && q1.size() != 0);
        #1;
        p0 = pop0;
        p1 = pop1;
        bad = (p0 && p1) || (p0 && fifo0_empty) || (p1 && fifo1_empty) || ((p0 || p1) && almost_full);
        check("pop legality", 32'(bad), 32'd0);
        if (chk_pop) check("pop0/pop1", {30'd0, p0, p1}, {30'd0, xp0, xp1});
        @(posedge clk);
        cyc++;
        #1;
        if (p0 && q0.size() > 0) begin
            w = q0.pop_front();
            fifo0_data = w;
            sb.push_back('{1'b0, w, cyc + 1});
        end else begin
            fifo0_data = DW'($urandom);
        end
        if (p1 && q1.size() > 0) begin
            w = q1.pop_front();
            fifo1_data = w;
            sb.push_back('{1'b1, w, cyc + 1});
        end else begin
            fifo1_data = DW'($urandom);
        end
        @(negedge clk);
        check_out();
        if (chk_st) check("state", 32'(state), 32'(xst));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // grant sequence from reset release (last=1 so source 0 goes first)
        vecs[0]  = mk(1, 1, 0, 1, 0, 2'b01);
        vecs[1]  = mk(1, 1, 0, 1, 0, 2'b01);
        vecs[2]  = mk(1, 1, 0, 1, 0, 2'b01);
        vecs[3]  = mk(1, 1, 0, 1, 0, 2'b01);
        vecs[4]  = mk(1, 1, 0, 0, 1, 2'b10);
        vecs[5]  = mk(1, 1, 0, 0, 1, 2'b10);
        vecs[6]  = mk(1, 1, 0, 0, 1, 2'b10);
        vecs[7]  = mk(1, 1, 0, 0, 1, 2'b10);
        vecs[8]  = mk(1, 1, 0, 1, 0, 2'b01);
        vecs[9]  = mk(1, 1, 0, 1, 0, 2'b01);
        vecs[10] = mk(1, 1, 1, 0, 0, 2'b11);
        vecs[11] = mk(1, 1, 1, 0, 0, 2'b11);
        vecs[12] = mk(1, 1, 0, 0, 1, 2'b10);
        vecs[13] = mk(1, 0, 0, 1, 0, 2'b01);
        vecs[14] = mk(1, 1, 0, 1, 0, 2'b01);
        vecs[15] = mk(1, 0, 0, 1, 0, 2'b01);
        vecs[16] = mk(0, 0, 0, 0, 0, 2'b00);
        vecs[17] = mk(0, 1, 0, 0, 1, 2'b10);
        vecs[18] = mk(0, 0, 0, 0, 0, 2'b00);
        vecs[19] = mk(0, 0, 1, 0, 0, 2'b11);
        vecs[20] = mk(0, 0, 0, 0, 0, 2'b00);
        vecs[21] = mk(1, 1, 0, 1, 0, 2'b01);

        // reset held with both sources non-empty
        fill(40);
        en0 = 1'b1;
        en1 = 1'b1;
        @(negedge clk);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        check("idle in reset", 32'(idle), 32'd1);
        reset_L = 1'b1;

        for (int i = 0; i < 22; i++) begin
            en0 = vecs[i].m0;
            en1 = vecs[i].m1;
            almost_full = vecs[i].af;
            tick(1'b1, vecs[i].xp0, vecs[i].xp1, 1'b1, vecs[i].xst);
        end

        almost_full = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        check("idle after drain", 32'(idle), 32'd1);

        // single source with known words 3,5,9
        q0.delete();
        q1.delete();
        q0.push_back(4'h3);
        q0.push_back(4'h5);
        q0.push_back(4'h9);
        en0 = 1'b1;
        repeat (3) tick(1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        check("idle with last word showing", 32'(idle), 32'd0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        check("idle once drained", 32'(idle), 32'd1);

        // asynchronous reset while a word is in flight
        fill(10);
        en0 = 1'b1;
        en1 = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        #2;
        reset_L = 1'b0;
        #1;
        check("valid_out at reset", 32'(valid_out), 32'd0);
        check("data_out at reset", 32'(data_out), 32'd0);
        check("state at reset", 32'(state), 32'd0);
        check("pops at reset", {30'd0, pop0, pop1}, 32'd0);
        check("idle at reset", 32'(idle), 32'd1);
        sb.delete();
        @(negedge clk);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        reset_L = 1'b1;
        en0 = 1'b0;
        en1 = 1'b0;
        repeat (2) tick(1'b1, 1'b0, 1'b0, 1'b1, 2'b00);
        en0 = 1'b1;
        tick(1'b1, 1'b1, 1'b0, 1'b1, 2'b01);
        en0 = 1'b0;
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        check("scoreboard drained", 32'(sb.size()), 32'd0);
        check("idle at end", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/arbitro_rr_fifo2.md
Name: arbitro_rr_fifo2

Overview:
Round-robin arbiter that shares one 2:1 output datapath between two source FIFOs. Each cycle it decides which FIFO to pop, with burst-limited stickiness, and stops under downstream backpressure. It also drives the registered 2:1 selection of the popped word toward the downstream FIFO. It sits between the per-lane input FIFOs and the mux/demux stage of the L1 datapath.

Parameters:
DATA_WIDTH, 4, width of each data word.
BURST_MAX, 4, maximum consecutive grants to one source while the other source is non-empty; legal range ≥1.

Ports:
clk  input  1  single clock, rising edge.
reset_L  input  1  asynchronous active-low reset.
fifo0_empty  input  1  source 0 empty flag.
fifo1_empty  input  1  source 1 empty flag.
fifo0_data  input  DATA_WIDTH  source 0 read data, valid the cycle after pop0.
fifo1_data  input  DATA_WIDTH  source 1 read data, valid the cycle after pop1.
almost_full  input  1  downstream FIFO backpressure.
pop0  output  1  read strobe to source 0 (combinational).
pop1  output  1  read strobe to source 1 (combinational).
data_out  output  DATA_WIDTH  registered selected word.
valid_out  output  1  registered; data_out is meaningful.
selector  output  1  registered; source of the current data_out.
state  output  2  FSM state, for debug.
idle  output  1  high when state==IDLE and no word is in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_L.
- While reset_L=0: all registers are cleared, with state=IDLE, last=1, cnt=0, data_out=0, valid_out=0, selector=0. pop0 and pop1 are forced to 0. idle=1. On release, operation starts on the next rising edge.
- FSM states:
  - IDLE=00.
  - SERVE0=01.
  - SERVE1=10.
  - HOLD=11.
  - state always equals the grant decision of the previous cycle.
- Grant decision (combinational, each cycle), with e0=!fifo0_empty and e1=!fifo1_empty:
  - almost_full=1: no pop. Next state is HOLD, even from IDLE.
  - Else, neither e0 nor e1: no pop. Next state is IDLE.
  - Else, exactly one of e0/e1 set: grant that source.
  - Else, both set and state in {IDLE, HOLD}: grant !last.
  - Else, both set and state=SERVEi: grant i if cnt<BURST_MAX, otherwise grant the other source.
- On a grant to g:
  - pop_g=1 in the same cycle.
  - Next state is SERVEg and last<=g.
  - cnt<=cnt+1 (saturating at BURST_MAX) if g==last and state==SERVEg; otherwise cnt<=1.
  - cnt width is clog2(BURST_MAX+1).
- pop0 and pop1 are never asserted together. Neither is ever asserted for an empty source or while almost_full=1.
- Datapath pipeline, for a pop in cycle N:
  - At edge N: pend<=1 and src<=g.
  - At edge N+1: valid_out<=pend, selector<=src, data_out<=(src ? fifo1_data : fifo0_data).
  - The word is therefore visible on the outputs in cycle N+2. Throughput is one word per cycle.
- When pend=0 at an edge: valid_out<=0 and data_out<=0; selector holds its previous value.
- In-flight words are always delivered, including after almost_full rises. Downstream must reserve ≥2 entries of slack above its almost_full threshold.
- idle = (state==IDLE) && !pend && !valid_out.
- Reset mid-operation: in-flight words are dropped, and no stale valid_out appears after reset release.

Decomposition:
- Shared package (L1 package): state encodings IDLE/SERVE0/SERVE1/HOLD, default DATA_WIDTH, default BURST_MAX.
- Sub-module mux2_valid_reg: the registered 2:1 output stage (pend/src in; data_out/valid_out/selector out, zero data when invalid), on clk/reset_L.
- The arbiter FSM and counter stay in the top module.

Test Plan:
1. reset_L=0 with both FIFOs non-empty and almost_full=0 -> pop0=pop1=0, data_out=0, valid_out=0, state=00, idle=1. Release reset -> first pop is pop0 (last resets to 1).
2. Only fifo0 non-empty, with words 0x3,0x5,0x9 popped in cycles 1..3 -> valid_out=1 in cycles 3..5, data_out 0x3,0x5,0x9, selector=0. Then idle=1 from cycle 6.
3. Both non-empty continuously, BURST_MAX=4 -> grant sequence 0,0,0,0,1,1,1,1,0,… with no gap cycles and each data_out matching its source in order.
4. Serving 0 with cnt=2, almost_full rises -> pops stop in the same cycle, state=HOLD, and the 2 in-flight words still appear. almost_full falls with both non-empty -> pop1 first.
5. Serving 0 with cnt=1, fifo1 non-empty for one cycle only -> grant stays on 0 (sticky), pop1 never asserted.
6. reset_L pulsed low asynchronously mid-cycle while pend=1 -> valid_out and data_out go 0 immediately and state=00. After release, no valid_out until a new pop plus 2 cycles.
